// File: rtl/game_state_pkg.sv
// Shared game-state code definitions for the game FSM and its consumers.
// Latency: n/a (constants and a pure decode helper only).
// Backpressure: none.
package game_state_pkg;

  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] CODE_START    = 3'd0;
  localparam logic [CODE_W-1:0] CODE_PLAYING  = 3'd1;
  localparam logic [CODE_W-1:0] CODE_PAUSE    = 3'd2;
  localparam logic [CODE_W-1:0] CODE_RESET    = 3'd3;
  localparam logic [CODE_W-1:0] CODE_GAMEOVER = 3'd4;

  // Codes above GAMEOVER are not driven by a healthy game FSM.
  function automatic logic code_is_legal(input logic [CODE_W-1:0] code);
    return (code <= CODE_GAMEOVER);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter with enable, synchronous clear and wrap flag.
// Latency: wrap_o is decoded from the count register (asserts on the last count).
// Backpressure: none; en_i=0 freezes the count, clr_i zeroes it (clr_i wins).
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   en_i       : advance the count this cycle
//   clr_i      : zero the count this cycle
//   wrap_o     : high while enabled on count DIV-1 (the count wraps next edge)
module tick_divider #(
  parameter int DIV = 50000,
  parameter int W   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_o
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wrap_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/game_state_decoder.sv
// Decodes the registered game-state code into movement tick, pause blink,
// frame-memory clear sweep, start pulse and game-over controls.
// Latency: code -> FSM state 2 cycles; all outputs decoded from registers.
// Backpressure: none; a clear sweep always completes before code_q is obeyed.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   state_code   : 3-bit game state from the game FSM
//   move_tick    : 1-cycle pulse every TICK_DIV cycles while playing
//   blink        : pause overlay, toggles every BLINK_TICKS divider wraps
//   clr_we/addr  : frame-memory clear write strobe and address
//   clr_done     : sweep finished and code still RESET
//   start_pulse  : 1-cycle pulse on IDLE -> RUN
//   gameover     : level while in game-over
//   illegal_code : high while the registered code is 5..7
module game_state_decoder
  import game_state_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int TICK_W      = 16,
  parameter int BLINK_TICKS = 25,
  parameter int CLEAR_DEPTH = 64,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] state_code,
  output logic              move_tick,
  output logic              blink,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_done,
  output logic              start_pulse,
  output logic              gameover,
  output logic              illegal_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_CLEAR,
    S_CLEARED,
    S_OVER
  } state_t;

  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(CLEAR_DEPTH - 1);

  logic [CODE_W-1:0]  code_q;
  state_t             state_q, state_d;
  state_t             prev_q;
  state_t             target_s;
  logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic               code_legal;
  logic               div_en, div_clr, div_wrap;

  assign code_legal = code_is_legal(code_q);

  // State a legal code asks for; illegal codes hold the current state.
  always_comb begin
    target_s = state_q;
    case (code_q)
      CODE_START:    target_s = S_IDLE;
      CODE_PLAYING:  target_s = S_RUN;
      CODE_PAUSE:    target_s = S_HOLD;
      CODE_RESET:    target_s = S_CLEAR;
      CODE_GAMEOVER: target_s = S_OVER;
      default:       target_s = state_q;
    endcase
  end

  always_comb begin
    state_d = target_s;
    if (state_q == S_CLEAR) begin
      // The sweep ignores code_q until its last word; the exit then obeys
      // code_q, with RESET or an illegal code settling in CLEARED.
      if (clr_addr_q != ADDR_LAST) begin
        state_d = S_CLEAR;
      end else if (!code_legal || code_q == CODE_RESET) begin
        state_d = S_CLEARED;
      end else begin
        state_d = target_s;
      end
    end else if (state_q == S_CLEARED && code_q == CODE_RESET) begin
      state_d = S_CLEARED;
    end
  end

  always_comb begin
    clr_addr_d = '0;
    if (state_q == S_CLEAR && clr_addr_q != ADDR_LAST) begin
      clr_addr_d = clr_addr_q + 1'b1;
    end
  end

  // Divider runs in RUN/HOLD so the tick phase survives a pause.
  assign div_en  = (state_q == S_RUN) || (state_q == S_HOLD);
  assign div_clr = (state_d == S_CLEAR);

  tick_divider #(
    .DIV (TICK_DIV),
    .W   (TICK_W)
  ) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .en_i   (div_en),
    .clr_i  (div_clr),
    .wrap_o (div_wrap)
  );

  // Blink state is zeroed on any edge that does not stay in HOLD, so the
  // registered blink can only be high while state_q is HOLD.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (state_d != S_HOLD) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (state_q == S_HOLD && div_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q      <= CODE_START;
      state_q     <= S_IDLE;
      prev_q      <= S_IDLE;
      clr_addr_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      code_q      <= state_code;
      state_q     <= state_d;
      prev_q      <= state_q;
      clr_addr_q  <= clr_addr_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign move_tick    = div_wrap && (state_q == S_RUN);
  assign blink        = blink_q;
  assign clr_we       = (state_q == S_CLEAR);
  assign clr_addr     = clr_addr_q;
  assign clr_done     = (state_q == S_CLEARED);
  assign start_pulse  = (state_q == S_RUN) && (prev_q == S_IDLE);
  assign gameover     = (state_q == S_OVER);
  assign illegal_code = !code_legal;

endmodule

// File: tb/tb_game_state_decoder.sv
// Directed bench for game_state_decoder with small parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_game_state_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_code;
  logic       move_tick, blink, clr_we, clr_done, start_pulse, gameover, illegal_code;
  logic [2:0] clr_addr;

  int tests_run    = 0;
  int tests_failed = 0;

  game_state_decoder #(
    .TICK_DIV    (4),
    .TICK_W      (16),
    .BLINK_TICKS (2),
    .CLEAR_DEPTH (8),
    .ADDR_W      (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .state_code   (state_code),
    .move_tick    (move_tick),
    .blink        (blink),
    .clr_we       (clr_we),
    .clr_addr     (clr_addr),
    .clr_done     (clr_done),
    .start_pulse  (start_pulse),
    .gameover     (gameover),
    .illegal_code (illegal_code)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just past the edge; inputs change here too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] all_outs();
    return {move_tick, blink, clr_we, clr_addr, clr_done, start_pulse, gameover, illegal_code};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    state_code = 3'd0;
    step();
    step();
    tests_run++;
    if (all_outs() !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want 0", all_outs());
    end
    reset = 1'b0;
    step();
    tests_run++;
    if (all_outs() !== 10'd0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %b want 0", all_outs());
    end
  endtask

  task automatic test_start_run();
    int ticks = 0;
    state_code = 3'd1;
    for (int i = 1; i <= 14; i++) begin
      step();
      tests_run++;
      if (start_pulse !== (i == 2)) begin
        tests_failed++;
        $display("FAIL start_pulse cyc%0d: got %b want %b", i, start_pulse, (i == 2));
      end
      tests_run++;
      if (move_tick !== (i == 5 || i == 9 || i == 13)) begin
        tests_failed++;
        $display("FAIL run_tick cyc%0d: got %b", i, move_tick);
      end
      if (i >= 3 && move_tick === 1'b1) ticks++;
    end
    tests_run++;
    if (ticks != 3) begin
      tests_failed++;
      $display("FAIL tick_count_12: got %0d want 3", ticks);
    end
  endtask

  task automatic test_pause();
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (move_tick === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL pause_pre_tick: got none want tick within 8");
    end
    step();
    step();
    state_code = 3'd2;
    for (int k = 1; k <= 20; k++) begin
      step();
      tests_run++;
      if (move_tick !== 1'b0) begin
        tests_failed++;
        $display("FAIL pause_no_tick cyc%0d: got %b want 0", k, move_tick);
      end
      tests_run++;
      if (blink !== (k >= 7 && k < 15)) begin
        tests_failed++;
        $display("FAIL pause_blink cyc%0d: got %b want %b", k, blink, (k >= 7 && k < 15));
      end
    end
    state_code = 3'd1;
    for (int k = 1; k <= 4; k++) begin
      step();
      tests_run++;
      if (blink !== 1'b0) begin
        tests_failed++;
        $display("FAIL resume_blink cyc%0d: got %b want 0", k, blink);
      end
      tests_run++;
      if (move_tick !== (k == 2) || start_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL resume_tick cyc%0d: got tick=%b start=%b want tick=%b start=0",
                 k, move_tick, start_pulse, (k == 2));
      end
    end
  endtask

  task automatic test_clear();
    state_code = 3'd3;
    step();
    tests_run++;
    if (clr_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_latency: got we=%b want 0", clr_we);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      tests_run++;
      if (clr_we !== 1'b1 || clr_addr !== 3'(i) || clr_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL clear_sweep %0d: got we=%b addr=%0d done=%b want we=1 addr=%0d done=0",
                 i, clr_we, clr_addr, clr_done, i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (clr_we !== 1'b0 || clr_done !== 1'b1 || clr_addr !== 3'd0) begin
        tests_failed++;
        $display("FAIL cleared_hold %0d: got we=%b done=%b addr=%0d want 0/1/0",
                 i, clr_we, clr_done, clr_addr);
      end
    end
    state_code = 3'd0;
    step();
    tests_run++;
    if (clr_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL cleared_exit_latency: got done=%b want 1", clr_done);
    end
    step();
    tests_run++;
    if (all_outs() !== 10'd0) begin
      tests_failed++;
      $display("FAIL cleared_to_idle: got %b want 0", all_outs());
    end
  endtask

  task automatic test_clear_exit();
    state_code = 3'd3;
    step();
    state_code = 3'd1;
    for (int i = 0; i < 8; i++) begin
      step();
      tests_run++;
      if (clr_we !== 1'b1 || clr_addr !== 3'(i) || start_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL sweep_uninterrupted %0d: got we=%b addr=%0d start=%b want we=1 addr=%0d start=0",
                 i, clr_we, clr_addr, start_pulse, i);
      end
    end
    for (int j = 1; j <= 4; j++) begin
      step();
      tests_run++;
      if (clr_we !== 1'b0 || clr_done !== 1'b0 || start_pulse !== 1'b0 || move_tick !== (j == 4)) begin
        tests_failed++;
        $display("FAIL clear_to_run cyc%0d: got we=%b done=%b start=%b tick=%b want 0/0/0/%b",
                 j, clr_we, clr_done, start_pulse, move_tick, (j == 4));
      end
    end
  endtask

  task automatic test_reset_sweep();
    state_code = 3'd3;
    step();
    for (int i = 0; i <= 4; i++) begin
      step();
      tests_run++;
      if (clr_we !== 1'b1 || clr_addr !== 3'(i)) begin
        tests_failed++;
        $display("FAIL pre_reset_sweep %0d: got we=%b addr=%0d want 1/%0d", i, clr_we, clr_addr, i);
      end
    end
    reset = 1'b1;
    step();
    tests_run++;
    if (all_outs() !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_sweep: got %b want 0", all_outs());
    end
    state_code = 3'd0;
    step();
    reset = 1'b0;
    step();
    tests_run++;
    if (all_outs() !== 10'd0) begin
      tests_failed++;
      $display("FAIL after_reset_sweep: got %b want 0", all_outs());
    end
  endtask

  task automatic test_illegal_over();
    bit seen = 1'b0;
    state_code = 3'd1;
    step();
    step();
    tests_run++;
    if (start_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_pulse: got %b want 1", start_pulse);
    end
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (move_tick === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL illegal_pre_tick: got none want tick within 8");
    end
    state_code = 3'd6;
    for (int k = 1; k <= 4; k++) begin
      step();
      state_code = 3'd1;
      tests_run++;
      if (illegal_code !== (k == 1) || move_tick !== (k == 4)) begin
        tests_failed++;
        $display("FAIL illegal cyc%0d: got ill=%b tick=%b want ill=%b tick=%b",
                 k, illegal_code, move_tick, (k == 1), (k == 4));
      end
    end
    state_code = 3'd4;
    for (int k = 1; k <= 9; k++) begin
      step();
      tests_run++;
      if (move_tick !== 1'b0 || gameover !== (k >= 2)) begin
        tests_failed++;
        $display("FAIL over cyc%0d: got tick=%b over=%b want 0/%b", k, move_tick, gameover, (k >= 2));
      end
    end
    state_code = 3'd1;
    for (int k = 1; k <= 6; k++) begin
      step();
      tests_run++;
      if (gameover !== (k == 1) || move_tick !== (k == 4) || start_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL over_frozen cyc%0d: got over=%b tick=%b start=%b want %b/%b/0",
                 k, gameover, move_tick, start_pulse, (k == 1), (k == 4));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    state_code = 3'd0;
    test_reset();
    test_start_run();
    test_pause();
    test_clear();
    test_clear_exit();
    test_reset_sweep();
    test_illegal_over();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
